// File: rtl/systolic_array_feeder_is_pkg.sv
// Shared types for the input-stationary systolic array feeder.
//   feeder_state_t       : job sequencer states
//   default_pipe_latency : enabled array cycles from weight_in to psum_out
package systolic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } feeder_state_t;

  function automatic int unsigned default_pipe_latency(input int unsigned width,
                                                       input int unsigned height);
    return width + height - 1;
  endfunction

endpackage

// File: rtl/systolic_array_feeder_is_valid_pipe.sv
// Enabled shift register that shadows the array pipeline with {valid,last}
// tags so the feeder knows which psum_out cycles carry real data.
//   clk, rst_n           : clock, async active-low reset
//   en                   : advance (same enable as the array's process_en)
//   valid_in, last_in    : tag pushed at the head on each advance
//   valid_out, last_out  : tag at the tail (aligned with psum_out)
//   empty                : no valid tag anywhere in the pipe
//   tail_only            : no valid tag outside the tail stage
module valid_pipe #(
  parameter int unsigned DEPTH = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic valid_in,
  input  logic last_in,
  output logic valid_out,
  output logic last_out,
  output logic empty,
  output logic tail_only
);

  localparam logic [DEPTH-1:0] TAIL_BIT = DEPTH'(1) << (DEPTH - 1);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      last_q  <= '0;
    end else if (en) begin
      valid_q[0] <= valid_in;
      last_q[0]  <= valid_in && last_in;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        last_q[i]  <= last_q[i-1];
      end
    end
  end

  assign valid_out = valid_q[DEPTH-1];
  assign last_out  = valid_q[DEPTH-1] && last_q[DEPTH-1];
  assign empty     = (valid_q == '0);
  assign tail_only = ((valid_q & ~TAIL_BIT) == '0);

endmodule

// File: rtl/systolic_array_feeder_is.sv
// Sequencer/stream interface for an input-stationary systolic array:
// loads one stationary tile, streams a counted run of weight vectors, and
// returns psum vectors on a valid/ready stream with backpressure.
//   start/num_vectors/busy/done          : job control
//   in_valid/in_ready/in_data            : tile stream, one column per beat
//   w_valid/w_ready/w_data               : weight vector stream
//   out_valid/out_ready/out_data/out_last: psum vector stream
//   process_en/input_en/input_in/weight_in/psum_out : array side
module systolic_array_feeder_is
  import systolic_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH  = 16,
  parameter int unsigned WEIGHT_WIDTH = 16,
  parameter int unsigned PSUM_WIDTH   = 32,
  parameter int unsigned ARRAY_HEIGHT = 4,
  parameter int unsigned ARRAY_WIDTH  = 4,
  parameter int unsigned PIPE_LATENCY = default_pipe_latency(ARRAY_WIDTH, ARRAY_HEIGHT),
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [CNT_WIDTH-1:0]                 num_vectors,
  output logic                                 busy,
  output logic                                 done,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [ARRAY_HEIGHT*INPUT_WIDTH-1:0]  in_data,
  input  logic                                 w_valid,
  output logic                                 w_ready,
  input  logic [ARRAY_WIDTH*WEIGHT_WIDTH-1:0]  w_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [ARRAY_WIDTH*PSUM_WIDTH-1:0]    out_data,
  output logic                                 out_last,
  output logic                                 process_en,
  output logic                                 input_en,
  output logic [ARRAY_HEIGHT*INPUT_WIDTH-1:0]  input_in,
  output logic [ARRAY_WIDTH*WEIGHT_WIDTH-1:0]  weight_in,
  input  logic [ARRAY_WIDTH*PSUM_WIDTH-1:0]    psum_out
);

  localparam int unsigned BEAT_W = $clog2(ARRAY_WIDTH + 1);

  feeder_state_t        state, state_nx;
  logic [CNT_WIDTH-1:0] remain;
  logic [BEAT_W-1:0]    beat;
  logic                 adv;
  logic                 pipe_en, push_valid, push_last;
  logic                 pipe_empty, pipe_tail_only;

  // The whole array plus tag pipe only moves when the output is not stalled.
  assign adv = !(out_valid && !out_ready);

  always_comb begin
    state_nx   = state;
    in_ready   = 1'b0;
    input_en   = 1'b0;
    input_in   = '0;
    process_en = 1'b0;
    w_ready    = 1'b0;
    weight_in  = '0;
    pipe_en    = 1'b0;
    push_valid = 1'b0;
    push_last  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        input_en = in_valid;
        input_in = in_data;
        if (in_valid && beat == BEAT_W'(ARRAY_WIDTH - 1))
          state_nx = (remain == '0) ? ST_DRAIN : ST_STREAM;
      end
      ST_STREAM: begin
        process_en = adv;
        pipe_en    = adv;
        w_ready    = adv;
        weight_in  = w_valid ? w_data : '0;
        push_valid = w_valid && adv;
        push_last  = push_valid && (remain == CNT_WIDTH'(1));
        if (push_last) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        process_en = adv;
        pipe_en    = adv;
        // Leave on the cycle whose advance retires the last tagged vector,
        // so done follows the final output handshake by one cycle.
        if (pipe_empty || (adv && pipe_tail_only)) state_nx = ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      remain <= '0;
      beat   <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && start) begin
        remain <= num_vectors;
        beat   <= '0;
      end
      if (state == ST_LOAD && in_valid) beat <= beat + BEAT_W'(1);
      if (push_valid) remain <= remain - CNT_WIDTH'(1);
    end
  end

  valid_pipe #(
    .DEPTH (PIPE_LATENCY)
  ) u_valid_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (pipe_en),
    .valid_in  (push_valid),
    .last_in   (push_last),
    .valid_out (out_valid),
    .last_out  (out_last),
    .empty     (pipe_empty),
    .tail_only (pipe_tail_only)
  );

  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign out_data = out_valid ? psum_out : '0;

endmodule

// File: tb/tb_systolic_array_feeder_is.sv
module tb_systolic_array_feeder_is;

  localparam int IW = 16;
  localparam int WW = 16;
  localparam int PW = 32;
  localparam int H  = 4;
  localparam int W  = 4;
  localparam int L  = W + H - 1;
  localparam int CW = 16;
  localparam int SNAP_W = 8 + H*IW + W*WW + W*PW;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [CW-1:0] num_vectors;
  logic busy, done;
  logic in_valid, in_ready;
  logic [H*IW-1:0] in_data;
  logic w_valid, w_ready;
  logic [W*WW-1:0] w_data;
  logic out_valid, out_ready, out_last;
  logic [W*PW-1:0] out_data;
  logic process_en, input_en;
  logic [H*IW-1:0] input_in;
  logic [W*WW-1:0] weight_in;
  logic [W*PW-1:0] psum_out;

  systolic_array_feeder_is #(
    .INPUT_WIDTH  (IW),
    .WEIGHT_WIDTH (WW),
    .PSUM_WIDTH   (PW),
    .ARRAY_HEIGHT (H),
    .ARRAY_WIDTH  (W),
    .PIPE_LATENCY (L),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk (clk), .rst_n (rst_n), .start (start), .num_vectors (num_vectors),
    .busy (busy), .done (done),
    .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data),
    .w_valid (w_valid), .w_ready (w_ready), .w_data (w_data),
    .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data), .out_last (out_last),
    .process_en (process_en), .input_en (input_en), .input_in (input_in),
    .weight_in (weight_in), .psum_out (psum_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural stand-in for the PE array: column shift-in tile, psum after L enabled cycles.
  logic [IW-1:0] tile_m [H][W];
  logic [W*PW-1:0] ppipe [L];

  function automatic logic [W*PW-1:0] array_mac(input logic [W*WW-1:0] wv);
    logic [W*PW-1:0] r;
    r = '0;
    for (int c = 0; c < W; c++)
      for (int k = 0; k < H; k++)
        r[c*PW +: PW] = r[c*PW +: PW] + PW'(tile_m[k][c]) * PW'(wv[k*WW +: WW]);
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < L; i++) ppipe[i] <= '0;
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) tile_m[r][c] <= '0;
    end else begin
      if (input_en) begin
        for (int r = 0; r < H; r++) begin
          for (int c = 1; c < W; c++) tile_m[r][c] <= tile_m[r][c-1];
          tile_m[r][0] <= input_in[r*IW +: IW];
        end
      end
      if (process_en) begin
        ppipe[0] <= array_mac(weight_in);
        for (int i = 1; i < L; i++) ppipe[i] <= ppipe[i-1];
      end
    end
  end
  assign psum_out = ppipe[L-1];

  int errors = 0;
  int checks = 0;

  // Intended tile [row][col] and weight base; expectations derive from these.
  int exp_tile [H][W];
  int wbase;

  function automatic int wval(input int k, input int e);
    return wbase + 4*k + e + 1;
  endfunction

  function automatic logic [W*PW-1:0] exp_psum(input int k);
    logic [W*PW-1:0] r;
    int s;
    for (int c = 0; c < W; c++) begin
      s = 0;
      for (int q = 0; q < H; q++) s += exp_tile[q][c] * wval(k, q);
      r[c*PW +: PW] = PW'(s);
    end
    return r;
  endfunction

  function automatic logic [SNAP_W-1:0] outs_snapshot();
    return {busy, done, in_ready, w_ready, out_valid, out_last, process_en, input_en,
            input_in, weight_in, out_data};
  endfunction

  // Scoreboard and per-job observations
  logic [W*PW-1:0] exp_q[$];
  logic exp_last_q[$];
  logic [W*PW-1:0] seen_exp[$], seen_act[$];
  logic seen_exp_last[$], seen_act_last[$];
  int start_cyc, first_acc, first_out, last_hs, done_at;
  int n_out, n_inen, inen_bad, n_acc, n_vcyc, stall_cycles, stall_pe, stall_chg;
  bit start_ok, timeout, aborted;
  logic [SNAP_W-1:0] snap;

  task automatic set_tile(input bit identity);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        exp_tile[r][c] = identity ? int'(r == c) : r*4 + c + 1;
  endtask

  task automatic run_job(input int n, input bit in_gaps, input bit w_toggle,
                         input bit stall, input int abort_after);
    int j = 0, k = 0, stall_used = 0, jj;
    bit prev_stall = 0;
    logic [W*PW-1:0] prev_data = '0;
    logic [W*PW-1:0] e;
    logic el;
    exp_q.delete(); exp_last_q.delete();
    seen_exp.delete(); seen_act.delete(); seen_exp_last.delete(); seen_act_last.delete();
    first_acc = -1; first_out = -1; last_hs = -1; done_at = -1;
    n_out = 0; n_inen = 0; inen_bad = 0; n_acc = 0; n_vcyc = 0;
    stall_cycles = 0; stall_pe = 0; stall_chg = 0;
    timeout = 0; aborted = 0;
    @(negedge clk);
    start = 1'b1; num_vectors = CW'(n); start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    #1;
    start_ok = busy && in_ready;
    for (int t = 0; t < 400; t++) begin
      if (t > 0) @(negedge clk);
      in_valid = in_gaps ? (t % 3 != 1) : 1'b1;
      jj = (j < W) ? j : 0;
      for (int r = 0; r < H; r++) in_data[r*IW +: IW] = IW'(exp_tile[r][W-1-jj]);
      w_valid = w_toggle ? (t % 2 == 0) : 1'b1;
      for (int q = 0; q < W; q++) w_data[q*WW +: WW] = w_valid ? WW'(wval(k, q)) : WW'(16'hdead);
      out_ready = !(stall && n_out == 1 && stall_used < 5);
      #1;
      if (done) begin done_at = cyc; break; end
      if (input_en) n_inen++;
      if (input_en && !in_valid) inen_bad++;
      if (in_valid && in_ready) j++;
      if (w_valid && w_ready) begin
        if (n_acc == 0) first_acc = cyc;
        exp_q.push_back(exp_psum(k));
        exp_last_q.push_back(k == n - 1);
        k++; n_acc++;
      end
      if (out_valid) begin
        n_vcyc++;
        if (first_out < 0) first_out = cyc;
      end
      if (out_valid && !out_ready) begin
        stall_cycles++;
        if (process_en) stall_pe++;
        if (prev_stall && out_data !== prev_data) stall_chg++;
        prev_stall = 1; prev_data = out_data;
      end else prev_stall = 0;
      if (!out_ready) stall_used++;
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front(); el = exp_last_q.pop_front();
        end else begin
          e = '1; el = 1'b0;
        end
        seen_exp.push_back(e); seen_act.push_back(out_data);
        seen_exp_last.push_back(el); seen_act_last.push_back(out_last);
        n_out++; last_hs = cyc;
      end
      if (abort_after > 0 && n_acc == abort_after) begin
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        snap = outs_snapshot();
        aborted = 1;
        break;
      end
    end
    if (!aborted && done_at < 0) timeout = 1;
    in_valid = 1'b0; w_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    #1;
    snap = outs_snapshot();
    checks++;
    if (snap !== '0) begin
      errors++; $display("FAIL reset_outputs got=%h want=0", snap);
    end
  endtask

  task automatic test_basic;
    wbase = 0; set_tile(1'b1);
    run_job(2, 1'b0, 1'b0, 1'b0, 0);
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("FAIL basic_timeout got=%0d want=0", timeout); end
    checks++;
    if (start_ok !== 1'b1) begin errors++; $display("FAIL basic_start_busy got=%0d want=1", start_ok); end
    checks++;
    if (first_out - first_acc !== L) begin
      errors++; $display("FAIL basic_latency got=%0d want=%0d", first_out - first_acc, L);
    end
    checks++;
    if (n_out !== 2) begin errors++; $display("FAIL basic_count got=%0d want=2", n_out); end
    for (int i = 0; i < seen_act.size(); i++) begin
      checks++;
      if (seen_act[i] !== seen_exp[i]) begin
        errors++; $display("FAIL basic_data[%0d] got=%h want=%h", i, seen_act[i], seen_exp[i]);
      end
      checks++;
      if (seen_act_last[i] !== seen_exp_last[i]) begin
        errors++; $display("FAIL basic_last[%0d] got=%0b want=%0b", i, seen_act_last[i], seen_exp_last[i]);
      end
    end
    checks++;
    if (done_at !== last_hs + 1) begin
      errors++; $display("FAIL basic_done_cycle got=%0d want=%0d", done_at, last_hs + 1);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got=%0b want=0", busy); end
  endtask

  task automatic test_zero_vectors;
    wbase = 0; set_tile(1'b1);
    run_job(0, 1'b0, 1'b0, 1'b0, 0);
    checks++;
    if (n_vcyc !== 0) begin errors++; $display("FAIL zero_out_valid got=%0d want=0", n_vcyc); end
    checks++;
    if (n_inen !== W) begin errors++; $display("FAIL zero_load_beats got=%0d want=%0d", n_inen, W); end
    checks++;
    if (done_at !== start_cyc + 6) begin
      errors++; $display("FAIL zero_done_cycle got=%0d want=%0d", done_at, start_cyc + 6);
    end
  endtask

  task automatic test_stall;
    wbase = 20; set_tile(1'b0);
    run_job(6, 1'b0, 1'b0, 1'b1, 0);
    checks++;
    if (stall_cycles !== 5) begin errors++; $display("FAIL stall_cycles got=%0d want=5", stall_cycles); end
    checks++;
    if (stall_pe !== 0) begin errors++; $display("FAIL stall_process_en got=%0d want=0", stall_pe); end
    checks++;
    if (stall_chg !== 0) begin errors++; $display("FAIL stall_data_stable got=%0d want=0", stall_chg); end
    checks++;
    if (n_out !== 6) begin errors++; $display("FAIL stall_count got=%0d want=6", n_out); end
    for (int i = 0; i < seen_act.size(); i++) begin
      checks++;
      if (seen_act[i] !== seen_exp[i] || seen_act_last[i] !== seen_exp_last[i]) begin
        errors++;
        $display("FAIL stall_data[%0d] got=%h/%0b want=%h/%0b", i, seen_act[i], seen_act_last[i],
                 seen_exp[i], seen_exp_last[i]);
      end
    end
  endtask

  task automatic test_bubbles;
    wbase = 40; set_tile(1'b0);
    run_job(6, 1'b0, 1'b1, 1'b0, 0);
    checks++;
    if (n_vcyc !== 6) begin errors++; $display("FAIL bubble_valid_cycles got=%0d want=6", n_vcyc); end
    checks++;
    if (n_out !== 6) begin errors++; $display("FAIL bubble_count got=%0d want=6", n_out); end
    for (int i = 0; i < seen_act.size(); i++) begin
      checks++;
      if (seen_act[i] !== seen_exp[i] || seen_act_last[i] !== seen_exp_last[i]) begin
        errors++;
        $display("FAIL bubble_data[%0d] got=%h/%0b want=%h/%0b", i, seen_act[i], seen_act_last[i],
                 seen_exp[i], seen_exp_last[i]);
      end
    end
  endtask

  task automatic test_in_gaps;
    wbase = 7; set_tile(1'b0);
    run_job(3, 1'b1, 1'b0, 1'b0, 0);
    checks++;
    if (inen_bad !== 0) begin errors++; $display("FAIL gap_input_en got=%0d want=0", inen_bad); end
    checks++;
    if (n_inen !== W) begin errors++; $display("FAIL gap_load_beats got=%0d want=%0d", n_inen, W); end
    checks++;
    if (n_out !== 3) begin errors++; $display("FAIL gap_count got=%0d want=3", n_out); end
    for (int i = 0; i < seen_act.size(); i++) begin
      checks++;
      if (seen_act[i] !== seen_exp[i]) begin
        errors++; $display("FAIL gap_data[%0d] got=%h want=%h", i, seen_act[i], seen_exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_stream;
    wbase = 0; set_tile(1'b1);
    run_job(8, 1'b0, 1'b0, 1'b0, 3);
    checks++;
    if (aborted !== 1'b1) begin errors++; $display("FAIL midrst_reached got=%0d want=1", aborted); end
    checks++;
    if (snap !== '0) begin errors++; $display("FAIL midrst_outputs got=%h want=0", snap); end
    @(negedge clk);
    rst_n = 1'b1;
    run_job(2, 1'b0, 1'b0, 1'b0, 0);
    checks++;
    if (n_out !== 2 || timeout !== 1'b0) begin
      errors++; $display("FAIL midrst_rerun_count got=%0d want=2", n_out);
    end
    for (int i = 0; i < seen_act.size(); i++) begin
      checks++;
      if (seen_act[i] !== seen_exp[i] || seen_act_last[i] !== seen_exp_last[i]) begin
        errors++;
        $display("FAIL midrst_data[%0d] got=%h/%0b want=%h/%0b", i, seen_act[i], seen_act_last[i],
                 seen_exp[i], seen_exp_last[i]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num_vectors = '0;
    in_valid = 1'b0; in_data = '0; w_valid = 1'b0; w_data = '0; out_ready = 1'b1;
    wbase = 0;
    set_tile(1'b1);
    repeat (2) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    test_basic;
    test_zero_vectors;
    test_stall;
    test_bubbles;
    test_in_gaps;
    test_reset_mid_stream;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
